pipe_buf_stage: RTL and testbench
=================================

# pipe_buf_stage

Parametrised pipeline buffer register for the RISC-V five-stage pipeline, generalising the fixed IF/ID, ID/EX, EX/MEM and MEM/WB registers. Carries an opaque payload of WIDTH bits, typically a packed stage struct, between two pipeline stages using a valid/ready handshake. Supports synchronous flush to a programmable bubble value, an optional skid entry for full-throughput registered backpressure, and a saturating bubble counter for performance analysis.

## Interface
Parameters:
- WIDTH, default 64: payload width in bits (≥1).
- FLUSH_VAL, default '0: WIDTH-bit value loaded into data registers on reset and on flush. For example, the NOP encoding 0x00000013 in the instruction field.
- CNT_W, default 16: bubble counter width (≥2).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream stage presents in_data.
- in_ready  output  1  stage accepts in_data this cycle.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  out_data holds a live entry.
- out_ready  input  1  downstream consumes out_data this cycle.
- out_data  output  WIDTH  head payload.
- flush  input  1  synchronous kill of all held entries (branch/jump redirect).
- occupancy  output  2  number of live entries (0–2).
- bubble_cnt  output  CNT_W  saturating count of cycles with out_valid=0.

## Operation
- Accept: in_valid && in_ready at a rising edge. Deliver: out_valid && out_ready at a rising edge.
- Entries are delivered strictly in acceptance order. No entry is duplicated or dropped, except on flush.
- Main register (main_v, main_d) always drives out_valid and out_data.
- flush=1 at an edge:
  - Clears every valid bit and loads FLUSH_VAL into every data register.
  - An accept in the same cycle is discarded.
  - A deliver in the same cycle counts as completed.
  - flush has priority over all other updates.
- bubble_cnt increments by 1 at each edge where out_valid=0, including flush cycles. It holds at 2^CNT_W−1 and never wraps. It is cleared only by reset.
- Reset, asynchronous assertion: main_v=0, skid_v=0, data registers=FLUSH_VAL, out_valid=0, out_data=FLUSH_VAL, in_ready=1, occupancy=0, bubble_cnt=0.
- Reset asserted mid-transfer: all held entries are lost. The first accept after deassertion behaves as from empty.

## Timing
- Latency: an entry accepted at edge N appears with out_valid=1 in the cycle following edge N.
- Throughput: one entry per cycle when out_ready=1 continuously.
- in_valid must stay high and in_data must stay stable until the accept. out_valid follows the same rule toward downstream.
- out_data is stable while out_valid=1 and out_ready=0.
- Without skid (see Configuration):
  - in_ready = !main_v || out_ready. This is a combinational path from out_ready.
  - Simultaneous accept and deliver replace main_d and keep main_v=1.
- With skid:
  - in_ready = !skid_v, driven directly from a flop.
  - Accept while main_v=1 and no deliver: the entry goes to the skid register, skid_v=1.
  - Deliver while skid_v=1: skid moves into main, skid_v=0.
  - Accept into empty main, or into main that is delivering, loads main.
  - Full (occupancy=2): in_ready=0. Any in_valid is ignored until a deliver frees the skid.

## Configuration
- PIPE_BUF_SKID_EN defined:
  - Skid register is present.
  - in_ready is registered.
  - occupancy ranges 0–2.
- PIPE_BUF_SKID_EN undefined:
  - Skid logic is absent.
  - occupancy is 0–1; bit 1 is tied to 0.
  - in_ready is combinational as above.
- Reset and flush behaviour are identical in both builds.

## Test plan
- Reset with FLUSH_VAL=0x13, WIDTH=32: out_valid=0, out_data=0x13, in_ready=1, occupancy=0. bubble_cnt goes 0→3 over 3 idle cycles.
- Stream 0xA0..0xA7, in_valid=1, out_ready=1 constant: out_data shows 0xA0..0xA7 on consecutive cycles, first at one cycle of latency, with no gaps.
- Skid build, out_ready=0, push 0xB0, 0xB1, 0xB2: 0xB0 and 0xB1 accepted, occupancy=2, in_ready=0, 0xB2 held. Raise out_ready: 0xB0, 0xB1, 0xB2 delivered in order.
- Non-skid build, main holds 0xC0 and out_ready=0: in_ready=0. Set out_ready=1 with in_valid=1 and in_data=0xC1: same edge delivers 0xC0 and loads 0xC1.
- occupancy=2 (0xD0, 0xD1), flush=1 with in_valid=1 and in_data=0xD2: next cycle out_valid=0, occupancy=0, out_data=FLUSH_VAL. 0xD2 never appears.
- CNT_W=2, idle 6 cycles: bubble_cnt reads 1, 2, 3, 3, 3, 3. Saturated, no wrap.

Source files
------------

// File: rtl/pipe_buf_stage.sv
// pipe_buf_stage
// Valid/ready pipeline buffer register between two pipeline stages. It carries an
// opaque WIDTH-bit payload, supports a synchronous flush to FLUSH_VAL and keeps a
// saturating count of bubble cycles (cycles with out_valid=0).
//
// Optional feature macro: PIPE_BUF_SKID_EN
//   defined   : adds a skid entry, so in_ready comes from a flop and occupancy is 0..2.
//   undefined : single entry, in_ready = !main_v || out_ready, and occupancy is 0..1.
module pipe_buf_stage #(
  parameter int unsigned       WIDTH     = 64,
  parameter logic [WIDTH-1:0]  FLUSH_VAL = '0,
  parameter int unsigned       CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             main_v_q, main_v_d;
  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic [CNT_W-1:0] bubble_q, bubble_d;
  logic             accept;
  logic             deliver;

  // The main entry is always the head of the buffer.
  assign out_valid  = main_v_q;
  assign out_data   = main_data_q;
  assign bubble_cnt = bubble_q;

  assign accept  = in_valid && in_ready;
  assign deliver = main_v_q && out_ready;

`ifdef PIPE_BUF_SKID_EN
  logic             skid_v_q, skid_v_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;

  // Ready depends only on the skid flop, which breaks the combinational path from out_ready.
  assign in_ready  = !skid_v_q;
  assign occupancy = {1'b0, main_v_q} + {1'b0, skid_v_q};

  // Next state for main and skid. Flush wins. A full buffer only promotes skid into main.
  always_comb begin
    // NOTE: every _d gets a default here so no path leaves it unassigned (no latch).
    main_v_d    = main_v_q;
    main_data_d = main_data_q;
    skid_v_d    = skid_v_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      main_v_d    = 1'b0;
      main_data_d = FLUSH_VAL;
      skid_v_d    = 1'b0;
      skid_data_d = FLUSH_VAL;
    end else if (skid_v_q) begin
      // Full: in_ready is low, so the only possible event is a deliver.
      if (deliver) begin
        main_data_d = skid_data_q;
        skid_v_d    = 1'b0;
      end
    end else if (accept) begin
      if (!main_v_q || deliver) begin
        // The head is free or leaving this cycle, so the new entry takes its place.
        main_v_d    = 1'b1;
        main_data_d = in_data;
      end else begin
        // The head is stalled, so the new entry parks in the skid entry.
        skid_v_d    = 1'b1;
        skid_data_d = in_data;
      end
    end else if (deliver) begin
      main_v_d = 1'b0;
    end
  end

  // Skid entry registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      skid_v_q    <= 1'b0;
      skid_data_q <= FLUSH_VAL;
    end else begin
      skid_v_q    <= skid_v_d;
      skid_data_q <= skid_data_d;
    end
  end
`else
  // Single entry: it can take new data when it is empty or is being drained this cycle.
  assign in_ready  = !main_v_q || out_ready;
  assign occupancy = {1'b0, main_v_q};

  // Next state for main. Flush wins. Accepting while delivering replaces the head.
  always_comb begin
    // NOTE: every _d gets a default here so no path leaves it unassigned (no latch).
    main_v_d    = main_v_q;
    main_data_d = main_data_q;
    if (flush) begin
      main_v_d    = 1'b0;
      main_data_d = FLUSH_VAL;
    end else if (accept) begin
      main_v_d    = 1'b1;
      main_data_d = in_data;
    end else if (deliver) begin
      main_v_d = 1'b0;
    end
  end
`endif

  // Bubble counter: count cycles with no live head and hold at the maximum.
  always_comb begin
    bubble_d = bubble_q;
    if (!main_v_q && (bubble_q != CNT_MAX)) begin
      bubble_d = bubble_q + CNT_ONE;
    end
  end

  // Main entry and bubble counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the data register is reset too, because out_data must read FLUSH_VAL.
      main_v_q    <= 1'b0;
      main_data_q <= FLUSH_VAL;
      bubble_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments, so every register samples pre-edge values.
      main_v_q    <= main_v_d;
      main_data_q <= main_data_d;
      bubble_q    <= bubble_d;
    end
  end

endmodule

// File: tb/tb_pipe_buf_stage.sv
// tb_pipe_buf_stage
// Directed, table-driven bench for pipe_buf_stage (WIDTH=32, FLUSH_VAL=0x13). It also
// has a second instance with CNT_W=2 to check that the bubble counter saturates.
// The bench picks its skid or non-skid expectations from PIPE_BUF_SKID_EN.
module tb_pipe_buf_stage;

`ifdef PIPE_BUF_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  localparam logic [31:0] FV = 32'h0000_0013;

  typedef struct {
    logic        iv;
    logic [31:0] id;
    logic        ordy;
    logic        fl;
    logic        ov;   // expected out_valid before the edge
    logic [31:0] od;   // expected out_data before the edge
    logic        cd;   // compare out_data on this row
    logic        ir;   // expected in_ready
    logic [1:0]  occ;  // expected occupancy
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, flush;
  logic [31:0] in_data, out_data;
  logic [1:0]  occupancy;
  logic [15:0] bubble_cnt;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_flush;
  logic [7:0]  b_in_data, b_out_data;
  logic [1:0]  b_occupancy;
  logic [1:0]  b_bubble_cnt;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] exp_bc;
  vec_t        tbl[$];

  always #5 clk = ~clk;

  pipe_buf_stage #(.WIDTH(32), .FLUSH_VAL(FV), .CNT_W(16)) dut (
    .clk(clk), .reset(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .flush(flush), .occupancy(occupancy), .bubble_cnt(bubble_cnt)
  );

  pipe_buf_stage #(.WIDTH(8), .FLUSH_VAL(8'h5A), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .flush(b_flush), .occupancy(b_occupancy), .bubble_cnt(b_bubble_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic iv, input logic [31:0] id, input logic ordy,
                              input logic fl, input logic ov, input logic [31:0] od,
                              input logic cd, input logic ir, input logic [1:0] occ);
    vec_t v;
    v.iv = iv; v.id = id; v.ordy = ordy; v.fl = fl;
    v.ov = ov; v.od = od; v.cd = cd; v.ir = ir; v.occ = occ;
    return v;
  endfunction

  // Called at a negedge. It drives one cycle of inputs, checks the pre-edge outputs,
  // and then returns at the next negedge.
  task automatic apply(input vec_t v, input string name);
    in_valid  = v.iv;
    in_data   = v.id;
    out_ready = v.ordy;
    flush     = v.fl;
    #1;
    check({name, " outs"},
          {28'd0, out_valid, (v.cd ? out_data : 32'd0), in_ready, occupancy},
          {28'd0, v.ov, (v.cd ? v.od : 32'd0), v.ir, v.occ});
    check({name, " bubble"}, {48'd0, bubble_cnt}, {48'd0, exp_bc});
    if (!v.ov && exp_bc != 16'hFFFF) exp_bc = exp_bc + 16'd1;
    @(negedge clk);
  endtask

  initial begin
    int b_exp[6] = '{1, 2, 3, 3, 3, 3};
    vec_t idle;
    idle = mk(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, FV, 1'b1, 1'b1, 2'd0);

    rst_n = 1'b1;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0; b_flush = 1'b0;

    // Assert reset asynchronously, with no clock edge in between.
    #1 rst_n = 1'b0;
    #1;
    check("reset_async outs", {28'd0, out_valid, out_data, in_ready, occupancy},
          {28'd0, 1'b0, FV, 1'b1, 2'd0});
    check("reset_async bubble", {48'd0, bubble_cnt}, 64'd0);
    check("reset_async sat_inst", {54'd0, b_out_valid, b_out_data, b_in_ready},
          {54'd0, 1'b0, 8'h5A, 1'b1});
    @(negedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    exp_bc = '0;

    // Six idle cycles: the 16-bit counter goes 0,1,2,3,... and the 2-bit counter sticks at 3.
    for (int i = 0; i < 6; i++) begin
      apply(idle, $sformatf("idle[%0d]", i));
      check($sformatf("sat_bubble[%0d]", i), {62'd0, b_bubble_cnt}, 64'(b_exp[i]));
    end

    // Stream 0xA0..0xA7 with out_ready held high: one cycle of latency, then no gaps.
    tbl.push_back(mk(1'b1, 32'hA0, 1'b1, 1'b0, 1'b0, FV, 1'b1, 1'b1, 2'd0));
    for (int k = 1; k < 8; k++)
      tbl.push_back(mk(1'b1, 32'hA0 + 32'(k), 1'b1, 1'b0, 1'b1, 32'hA0 + 32'(k - 1), 1'b1, 1'b1, 2'd1));
    tbl.push_back(mk(1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 32'hA7, 1'b1, 1'b1, 2'd1));
    tbl.push_back(mk(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 2'd0));
    // Flush in the same cycle as a deliver and an accept: E1 is discarded.
    tbl.push_back(mk(1'b1, 32'hE0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 2'd0));
    tbl.push_back(mk(1'b1, 32'hE1, 1'b1, 1'b1, 1'b1, 32'hE0, 1'b1, 1'b1, 2'd1));
    tbl.push_back(mk(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, FV, 1'b1, 1'b1, 2'd0));
    tbl.push_back(mk(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, FV, 1'b1, 1'b1, 2'd0));
`ifdef PIPE_BUF_SKID_EN
    // Skid: B0 and B1 are accepted, B2 stalls while the buffer is full, then all drain in order.
    tbl.push_back(mk(1'b1, 32'hB0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 2'd0));
    tbl.push_back(mk(1'b1, 32'hB1, 1'b0, 1'b0, 1'b1, 32'hB0, 1'b1, 1'b1, 2'd1));
    tbl.push_back(mk(1'b1, 32'hB2, 1'b0, 1'b0, 1'b1, 32'hB0, 1'b1, 1'b0, 2'd2));
    tbl.push_back(mk(1'b1, 32'hB2, 1'b0, 1'b0, 1'b1, 32'hB0, 1'b1, 1'b0, 2'd2));
    tbl.push_back(mk(1'b1, 32'hB2, 1'b1, 1'b0, 1'b1, 32'hB0, 1'b1, 1'b0, 2'd2));
    tbl.push_back(mk(1'b1, 32'hB2, 1'b1, 1'b0, 1'b1, 32'hB1, 1'b1, 1'b1, 2'd1));
    tbl.push_back(mk(1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 32'hB2, 1'b1, 1'b1, 2'd1));
    tbl.push_back(mk(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 2'd0));
    // Flush while full, with D2 offered: the buffer empties and D2 never appears.
    tbl.push_back(mk(1'b1, 32'hD0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 2'd0));
    tbl.push_back(mk(1'b1, 32'hD1, 1'b0, 1'b0, 1'b1, 32'hD0, 1'b1, 1'b1, 2'd1));
    tbl.push_back(mk(1'b1, 32'hD2, 1'b0, 1'b1, 1'b1, 32'hD0, 1'b1, 1'b0, 2'd2));
    tbl.push_back(mk(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, FV, 1'b1, 1'b1, 2'd0));
    tbl.push_back(mk(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, FV, 1'b1, 1'b1, 2'd0));
`else
    // No skid: a stalled head drops in_ready. Releasing it delivers C0 and loads C1 on the same edge.
    tbl.push_back(mk(1'b1, 32'hC0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 2'd0));
    tbl.push_back(mk(1'b1, 32'hC1, 1'b0, 1'b0, 1'b1, 32'hC0, 1'b1, 1'b0, 2'd1));
    tbl.push_back(mk(1'b1, 32'hC1, 1'b1, 1'b0, 1'b1, 32'hC0, 1'b1, 1'b1, 2'd1));
    tbl.push_back(mk(1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 32'hC1, 1'b1, 1'b1, 2'd1));
    tbl.push_back(mk(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 2'd0));
    // Flush with the head stalled and D1 offered: the buffer empties and D1 never appears.
    tbl.push_back(mk(1'b1, 32'hD0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 2'd0));
    tbl.push_back(mk(1'b1, 32'hD1, 1'b0, 1'b1, 1'b1, 32'hD0, 1'b1, 1'b0, 2'd1));
    tbl.push_back(mk(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, FV, 1'b1, 1'b1, 2'd0));
    tbl.push_back(mk(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, FV, 1'b1, 1'b1, 2'd0));
`endif

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec[%0d]", i));

    // Reset in the middle of a transfer: every held entry is lost, and the next accept starts from empty.
    apply(mk(1'b1, 32'hF0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 2'd0), "rst_mid load0");
    apply(mk(1'b1, 32'hF1, 1'b0, 1'b0, 1'b1, 32'hF0, 1'b1, SKID, 2'd1), "rst_mid load1");
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid async outs", {28'd0, out_valid, out_data, in_ready, occupancy},
          {28'd0, 1'b0, FV, 1'b1, 2'd0});
    check("rst_mid async bubble", {48'd0, bubble_cnt}, 64'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    exp_bc = '0;
    apply(mk(1'b1, 32'hF2, 1'b0, 1'b0, 1'b0, FV, 1'b1, 1'b1, 2'd0), "rst_mid fresh");
    apply(mk(1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 32'hF2, 1'b1, 1'b1, 2'd1), "rst_mid head");
    apply(mk(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 2'd0), "rst_mid empty0");
    apply(mk(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 2'd0), "rst_mid empty1");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
